// File: rtl/sram_stream_reader.sv
// Read-side streamer for a double-buffered SRAM port 1.
// Issues credit-limited reads and streams words out via a 2-entry skid FIFO.
module sram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ONE = 1;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issue_left;
  logic [ADDR_WIDTH:0]   pop_left;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            occ;
  logic                  pop;
  logic                  push;
  logic                  issue;

  // Words already owed to the FIFO: stored plus the one on dout1.
  assign occ       = fifo_count + {1'b0, inflight};
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = inflight;
  assign csb1      = ~issue;
  assign addr1     = rd_addr;

  // Next state, read issue under credit, and status outputs.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue_left != '0 &&
            (occ < 2'd2 || (occ == 2'd2 && pop))) begin
          issue = 1'b1;
        end
        if (pop && pop_left == L_ONE) begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command latch plus address and remaining-word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr    <= '0;
      issue_left <= '0;
      pop_left   <= '0;
    end else if (state == IDLE && start) begin
      rd_addr    <= base_addr;
      issue_left <= length;
      pop_left   <= length;
    end else begin
      if (issue) begin
        rd_addr    <= rd_addr + A_ONE;
        issue_left <= issue_left - L_ONE;
      end
      if (pop) begin
        pop_left <= pop_left - L_ONE;
      end
    end
  end

  // Tracks the read whose data appears on dout1 next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
    end
  end

  // Skid FIFO storage and pointers; data is never lost since occ <= 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= dout1;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: SRAM model, random data and backpressure,
// and a word-order/credit reference model.
module tb_sram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] length = '0;
  logic        csb1;
  logic [11:0] addr1;
  logic [31:0] dout1 = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:4095];
  int nvec = 0;
  int errs = 0;

  sram_stream_reader #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .csb1(csb1), .addr1(addr1), .dout1(dout1),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM read port.
  always @(posedge clk) begin
    if (!csb1) dout1 <= mem[addr1];
  end

  // Runs one command; entry and exit at 1 time unit after a rising edge.
  task automatic xfer(input int base, input int len, input int rdy_pct,
                      input bit poke, output int first_v,
                      output int first_i, output int last_i,
                      output int done_c, output int nwords,
                      output int ndone);
    int issued = 0;
    int popped = 0;
    int cyc = 0;
    int owed;
    bit fin = 0;
    bit stall = 0;
    bit pop;
    logic [31:0] held = '0;
    logic [31:0] want;
    first_v = -1; first_i = -1; last_i = -1;
    done_c = -1; nwords = 0; ndone = 0;
    start = 1'b1;
    base_addr = 12'(base);
    length = 13'(len);
    out_ready = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL idle_before_start busy=%b done=%b need 0 0",
               busy, done);
    end
    @(posedge clk); #1;
    cyc = 1;
    while (!fin && cyc < 20000) begin
      out_ready = ($urandom_range(99) < rdy_pct);
      if (poke && cyc == 3) begin
        start = 1'b1;
        base_addr = 12'h123;
        length = 13'd7;
      end else begin
        start = 1'b0;
      end
      #1;
      pop = out_valid && out_ready;
      owed = issued - popped;
      nvec++;
      if (busy !== 1'b1 || owed > 2) begin
        errs++;
        $display("FAIL busy_owed cyc=%0d busy=%b owed=%0d need 1 <=2",
                 cyc, busy, owed);
      end
      if (!csb1) begin
        nvec++;
        if (issued >= len || addr1 !== 12'((base + issued) % 4096) ||
            !(owed < 2 || (owed == 2 && pop))) begin
          errs++;
          $display("FAIL issue cyc=%0d addr1=%h need %h n=%0d owed=%0d",
                   cyc, addr1, 12'((base + issued) % 4096), issued, owed);
        end
        if (first_i < 0) first_i = cyc;
        last_i = cyc;
        issued++;
      end
      if (stall) begin
        nvec++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errs++;
          $display("FAIL stall_hold cyc=%0d data=%h valid=%b need %h 1",
                   cyc, out_data, out_valid, held);
        end
      end
      if (out_valid === 1'b1 && first_v < 0) first_v = cyc;
      if (pop) begin
        want = mem[(base + popped) % 4096];
        nvec++;
        if (popped >= len || out_data !== want) begin
          errs++;
          $display("FAIL word cyc=%0d idx=%0d data=%h need %h",
                   cyc, popped, out_data, want);
        end
        popped++;
        nwords++;
      end
      stall = out_valid && !out_ready;
      held = out_data;
      if (done === 1'b1) begin
        ndone++;
        done_c = cyc;
        fin = 1;
        nvec++;
        if (popped != len || csb1 !== 1'b1 || out_valid !== 1'b0) begin
          errs++;
          $display("FAIL done_state popped=%0d need %0d csb1=%b valid=%b",
                   popped, len, csb1, out_valid);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (!fin) begin
      errs++;
      $display("FAIL timeout no done after %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    nvec++;
    if (csb1 !== 1'b1 || addr1 !== 12'h000 || out_valid !== 1'b0 ||
        out_data !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL reset csb1=%b addr1=%h v=%b d=%h busy=%b done=%b",
               csb1, addr1, out_valid, out_data, busy, done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int fv, fi, li, dc, nw, nd;
    mem[16] = 32'hA0; mem[17] = 32'hA1;
    mem[18] = 32'hA2; mem[19] = 32'hA3;
    xfer(16, 4, 100, 0, fv, fi, li, dc, nw, nd);
    nvec++;
    if (fv != 3 || fi != 1 || li != 4 || dc != 7 || nw != 4 || nd != 1) begin
      errs++;
      $display("FAIL basic fv=%0d fi=%0d li=%0d dc=%0d nw=%0d nd=%0d need 3 1 4 7 4 1",
               fv, fi, li, dc, nw, nd);
    end
  endtask

  task automatic test_backpressure();
    int fv, fi, li, dc, nw, nd;
    for (int k = 0; k < 4; k++) begin
      xfer($urandom_range(4095), 16, 50, 0, fv, fi, li, dc, nw, nd);
      nvec++;
      if (nw != 16 || nd != 1) begin
        errs++;
        $display("FAIL backpressure words=%0d dones=%0d need 16 1", nw, nd);
      end
    end
  endtask

  task automatic test_wrap();
    int fv, fi, li, dc, nw, nd;
    xfer(12'hFFE, 4, 100, 0, fv, fi, li, dc, nw, nd);
    nvec++;
    if (nw != 4 || dc != 7) begin
      errs++;
      $display("FAIL wrap words=%0d done=%0d need 4 7", nw, dc);
    end
    xfer(12'hFFF, 9, 60, 0, fv, fi, li, dc, nw, nd);
    nvec++;
    if (nw != 9 || nd != 1) begin
      errs++;
      $display("FAIL wrap_bp words=%0d dones=%0d need 9 1", nw, nd);
    end
  endtask

  task automatic test_zero();
    int fv, fi, li, dc, nw, nd;
    xfer($urandom_range(4095), 0, 100, 0, fv, fi, li, dc, nw, nd);
    nvec++;
    if (dc != 1 || fi != -1 || nw != 0 || nd != 1) begin
      errs++;
      $display("FAIL zero done=%0d first_issue=%0d words=%0d need 1 -1 0",
               dc, fi, nw);
    end
  endtask

  task automatic test_ignored_start();
    int fv, fi, li, dc, nw, nd;
    xfer(12'h200, 4, 100, 1, fv, fi, li, dc, nw, nd);
    nvec++;
    if (nw != 4 || nd != 1 || dc != 7) begin
      errs++;
      $display("FAIL ign_start words=%0d dones=%0d done=%0d need 4 1 7",
               nw, nd, dc);
    end
    for (int c = 0; c < 4; c++) begin
      out_ready = 1'b1;
      #1;
      nvec++;
      if (busy !== 1'b0 || csb1 !== 1'b1 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL ign_idle busy=%b csb1=%b valid=%b need 0 1 0",
                 busy, csb1, out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    base_addr = 12'($urandom_range(4095));
    length = 13'd16;
    out_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_fill valid=%b busy=%b need 1 1", out_valid, busy);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (csb1 !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || addr1 !== 12'h000 || out_data !== 32'h0) begin
      errs++;
      $display("FAIL mid_reset csb1=%b v=%b busy=%b done=%b a=%h d=%h",
               csb1, out_valid, busy, done, addr1, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      nvec++;
      if (done !== 1'b0 || out_valid !== 1'b0 || csb1 !== 1'b1) begin
        errs++;
        $display("FAIL mid_quiet done=%b valid=%b csb1=%b need 0 0 1",
                 done, out_valid, csb1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int fv, fi, li, dc, nw, nd;
    for (int k = 0; k < 3; k++) begin
      xfer($urandom_range(4095), 4, 100, 0, fv, fi, li, dc, nw, nd);
      nvec++;
      if (fv != 3 || dc != 7 || nw != 4) begin
        errs++;
        $display("FAIL b2b fv=%0d done=%0d words=%0d need 3 7 4", fv, dc, nw);
      end
    end
  endtask

  task automatic test_full();
    int fv, fi, li, dc, nw, nd;
    xfer(0, 4096, 100, 0, fv, fi, li, dc, nw, nd);
    nvec++;
    if (nw != 4096 || dc != 4099 || li != 4096 || nd != 1) begin
      errs++;
      $display("FAIL full words=%0d done=%0d last_issue=%0d need 4096 4099 4096",
               nw, dc, li);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    test_reset();
    test_reset_mid();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_ignored_start();
    test_back_to_back();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
